// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
// LOG2N helper, bit-reverse function, sample layout, read FSM states.
package fft_pkg;

  localparam int BITREV_W = 13;
  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
  } sample_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  // Reverse the low 'bits' bits of v; upper bits come back zero.
  function automatic logic [BITREV_W-1:0] bitrev(
    input logic [BITREV_W-1:0] v,
    input int bits
  );
    logic [BITREV_W-1:0] r;
    r = {<<{v}};
    return r >> (BITREV_W - bits);
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample RAM: one write port, one registered read port.
// Ports: clk, rst, we/waddr/wdata, re/raddr/rdata; addr = {bank, index}.
module fft_pingpong_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder stage (ping-pong banks).
// Ports: clk, rst, enable_in, in_re/in_im -> enable_out, out_re/out_im,
// out_index. FFT_REORDER_FFTSHIFT_EN: emit DC-centred order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 64,
  parameter int WIDTH = 16,
  localparam int LOG2N = log2n(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             enable_out,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [LOG2N-1:0] out_index
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam logic [LOG2N-1:0] RD_XOR = LOG2N'(N / 2);
`else
  localparam logic [LOG2N-1:0] RD_XOR = '0;
`endif

  logic [LOG2N-1:0]    wr_cnt;
  logic                wr_bank;
  logic                wr_last;
  logic [BITREV_W-1:0] wr_rev;
  logic [1:0]          full;

  rd_state_e        state, state_n;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_n;
  logic             rd_bank, rd_bank_n;
  logic             rd_en;
  logic             rd_done;
  logic [LOG2N-1:0] rd_addr;

  logic [2*WIDTH-1:0] rdata;

  assign wr_rev  = bitrev(BITREV_W'(wr_cnt), LOG2N);
  assign wr_last = enable_in && (wr_cnt == LAST);
  assign rd_addr = rd_cnt ^ RD_XOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (enable_in) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_last) wr_bank <= ~wr_bank;
    end
  end

  // A bank is freed on the cycle its last address issues; the writer
  // may start refilling it at that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (rd_done) full[rd_bank] <= 1'b0;
      if (wr_last) full[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RD_IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_n;
      rd_cnt  <= rd_cnt_n;
      rd_bank <= rd_bank_n;
    end
  end

  always_comb begin
    state_n   = state;
    rd_cnt_n  = rd_cnt;
    rd_bank_n = rd_bank;
    rd_en     = 1'b0;
    rd_done   = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          state_n  = RD_READ;
          rd_cnt_n = '0;
        end
      end
      RD_READ: begin
        rd_en    = 1'b1;
        rd_cnt_n = rd_cnt + 1'b1;
        if (rd_cnt == LAST) begin
          rd_done   = 1'b1;
          rd_bank_n = ~rd_bank;
          rd_cnt_n  = '0;
          state_n   = full[~rd_bank] ? RD_READ : RD_IDLE;
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  fft_pingpong_ram #(
    .ADDR_W (LOG2N + 1),
    .DATA_W (2 * WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (enable_in),
    .waddr ({wr_bank, wr_rev[LOG2N-1:0]}),
    .wdata ({in_re, in_im}),
    .re    (rd_en),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rdata)
  );

  assign out_re = rdata[2*WIDTH-1:WIDTH];
  assign out_im = rdata[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_out <= 1'b0;
      out_index  <= '0;
    end else begin
      enable_out <= rd_en;
      out_index  <= rd_en ? rd_addr : '0;
    end
  end

endmodule
